// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD arithmetic blocks: multiplier FSM states, digit width,
// and the multiplier-digit clamp helper.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StAdd,
    StDone
  } bcd_mul_state_e;

  // Non-decimal multiplier digits (A-F) are treated as 9.
  function automatic logic [BCD_DIGIT_W-1:0] bcd_clamp(input logic [BCD_DIGIT_W-1:0] d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

endpackage

// File: rtl/bcd_adder.sv
// Combinational ripple-carry packed-BCD adder over NUM_DIGITS digits with carry in/out.
module bcd_adder
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic [NUM_DIGITS*BCD_DIGIT_W-1:0] i_a,
  input  logic [NUM_DIGITS*BCD_DIGIT_W-1:0] i_b,
  input  logic                              i_carry,
  output logic [NUM_DIGITS*BCD_DIGIT_W-1:0] o_sum,
  output logic                              o_carry
);

  logic [BCD_DIGIT_W:0] digit_sum;
  logic                 c;

  always_comb begin
    o_sum     = '0;
    digit_sum = '0;
    c         = i_carry;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      digit_sum = {1'b0, i_a[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
                + {1'b0, i_b[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
                + {{BCD_DIGIT_W{1'b0}}, c};
      // Decimal correction: skip the six unused binary codes.
      if (digit_sum > 5'd9) begin
        digit_sum = digit_sum + 5'd6;
        c         = 1'b1;
      end else begin
        c         = 1'b0;
      end
      o_sum[i*BCD_DIGIT_W +: BCD_DIGIT_W] = digit_sum[BCD_DIGIT_W-1:0];
    end
    o_carry = c;
  end

endmodule

// File: rtl/bcd_multiplier.sv
// Digit-serial shift-and-add packed-BCD multiplier, N x N -> 2N digits, start/done handshake.
// Define BCD_MUL_EARLY_EXIT_EN to spend only d add slots per multiplier digit d.
module bcd_multiplier
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_start,
  input  logic [NUM_DIGITS*BCD_DIGIT_W-1:0]   i_num_a,
  input  logic [NUM_DIGITS*BCD_DIGIT_W-1:0]   i_num_b,
  output logic                                o_busy,
  output logic                                o_done,
  output logic [2*NUM_DIGITS*BCD_DIGIT_W-1:0] o_product,
  output logic                                o_overflow
);

  localparam int unsigned OpW  = NUM_DIGITS * BCD_DIGIT_W;
  localparam int unsigned AccW = 2 * OpW;
  localparam int unsigned KW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  bcd_mul_state_e         state_q;
  logic [OpW-1:0]         a_q, b_q;
  logic [AccW-1:0]        acc_q;
  logic [KW-1:0]          k_q;
  logic [BCD_DIGIT_W-1:0] cnt_q, d_q;

  logic [AccW-1:0]        acc_sum, acc_shift, acc_next;
  logic [BCD_DIGIT_W-1:0] digit_sel;
  logic                   add_last;
  logic                   add_carry_unused;

  bcd_adder #(
    .NUM_DIGITS(2 * NUM_DIGITS)
  ) u_adder (
    .i_a    (acc_q),
    .i_b    ({{OpW{1'b0}}, a_q}),
    .i_carry(1'b0),
    .o_sum  (acc_sum),
    .o_carry(add_carry_unused)
  );

  assign digit_sel = bcd_clamp(b_q[k_q*BCD_DIGIT_W +: BCD_DIGIT_W]);
  assign acc_shift = {acc_q[AccW-BCD_DIGIT_W-1:0], {BCD_DIGIT_W{1'b0}}};
  assign acc_next  = (cnt_q < d_q) ? acc_sum : acc_q;
`ifdef BCD_MUL_EARLY_EXIT_EN
  assign add_last  = (cnt_q == d_q - 4'd1);
`else
  assign add_last  = (cnt_q == BCD_MAX_DIGIT - 4'd1);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      d_q        <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_product  <= '0;
      o_overflow <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            a_q     <= i_num_a;
            b_q     <= i_num_b;
            acc_q   <= '0;
            k_q     <= KW'(NUM_DIGITS - 1);
            o_busy  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          acc_q   <= acc_shift;
          cnt_q   <= '0;
          d_q     <= digit_sel;
          state_q <= StAdd;
`ifdef BCD_MUL_EARLY_EXIT_EN
          if (digit_sel == '0) begin
            if (k_q == '0) begin
              o_product  <= acc_shift;
              o_overflow <= |acc_shift[AccW-1:OpW];
              o_done     <= 1'b1;
              state_q    <= StDone;
            end else begin
              k_q     <= k_q - 1'b1;
              state_q <= StShift;
            end
          end
`endif
        end
        StAdd: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 4'd1;
          if (add_last) begin
            if (k_q == '0) begin
              // Register the result on entry so it is valid in the DONE cycle.
              o_product  <= acc_next;
              o_overflow <= |acc_next[AccW-1:OpW];
              o_done     <= 1'b1;
              state_q    <= StDone;
            end else begin
              k_q     <= k_q - 1'b1;
              state_q <= StShift;
            end
          end
        end
        StDone: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_multiplier.sv
// Directed self-checking bench for bcd_multiplier (N=4); latency expectations follow
// whether BCD_MUL_EARLY_EXIT_EN is defined.
module tb_bcd_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_a, num_b;
  logic        busy, done;
  logic [31:0] product;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  int done_cyc, pulses, busy_after;

  bcd_multiplier #(
    .NUM_DIGITS(4)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_num_a   (num_a),
    .i_num_b   (num_b),
    .o_busy    (busy),
    .o_done    (done),
    .o_product (product),
    .o_overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One multiplication; cycle c is sampled 1 time unit after the edge that starts it,
  // acceptance edge is edge 0. Optionally injects a stray start or a reset mid-run.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int inj_cyc,
                         input int rst_cyc, output int d_cyc, output int n_pulses,
                         output int b_after);
    @(posedge clk);
    #1;
    num_a = a;
    num_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    num_a    = 16'h0000;
    num_b    = 16'h0000;
    d_cyc    = -1;
    n_pulses = 0;
    b_after  = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 1) chk("busy_cycle1", 64'(busy), 64'd1);
      if (done) begin
        n_pulses++;
        if (d_cyc < 0) d_cyc = c;
      end
      if (d_cyc > 0 && c == d_cyc + 1) b_after = int'(busy);
      if (c == inj_cyc) begin
        num_a = 16'h9999;
        num_b = 16'h9999;
        start = 1'b1;
      end
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_product", 64'(product), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_a = '0;
    num_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", 64'(product), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;

    // 1234 x 5678 = 07006652, stray start at cycle 10 must be ignored.
    run_mul(16'h1234, 16'h5678, 10, 0, done_cyc, pulses, busy_after);
    chk("p1_product", 64'(product), 64'h07006652);
    chk("p1_overflow", 64'(overflow), 64'd1);
    chk("p1_pulses", 64'(pulses), 64'd1);
    chk("p1_busy_after", 64'(busy_after), 64'd0);
`ifdef BCD_MUL_EARLY_EXIT_EN
    chk("p1_latency", 64'(done_cyc), 64'd31);
`else
    chk("p1_latency", 64'(done_cyc), 64'd41);
`endif

    run_mul(16'h9999, 16'h9999, 0, 0, done_cyc, pulses, busy_after);
    chk("p2_product", 64'(product), 64'h99980001);
    chk("p2_overflow", 64'(overflow), 64'd1);
    chk("p2_latency", 64'(done_cyc), 64'd41);

    run_mul(16'h0000, 16'h4321, 0, 0, done_cyc, pulses, busy_after);
    chk("p3_product", 64'(product), 64'h0);
    chk("p3_overflow", 64'(overflow), 64'd0);
`ifdef BCD_MUL_EARLY_EXIT_EN
    chk("p3_latency", 64'(done_cyc), 64'd15);
`else
    chk("p3_latency", 64'(done_cyc), 64'd41);
`endif

    run_mul(16'h4321, 16'h0000, 0, 0, done_cyc, pulses, busy_after);
    chk("p4_product", 64'(product), 64'h0);
`ifdef BCD_MUL_EARLY_EXIT_EN
    chk("p4_latency", 64'(done_cyc), 64'd5);
`else
    chk("p4_latency", 64'(done_cyc), 64'd41);
`endif

    run_mul(16'h0007, 16'h0001, 0, 0, done_cyc, pulses, busy_after);
    chk("p5_product", 64'(product), 64'h00000007);
    chk("p5_overflow", 64'(overflow), 64'd0);
`ifdef BCD_MUL_EARLY_EXIT_EN
    chk("p5_latency", 64'(done_cyc), 64'd6);
`else
    chk("p5_latency", 64'(done_cyc), 64'd41);
`endif

    // Clamped multiplier digits: 0002 x 00A0 behaves as 0002 x 0090.
    run_mul(16'h0002, 16'h00A0, 0, 0, done_cyc, pulses, busy_after);
    chk("p6_clamp_product", 64'(product), 64'h00000180);

    // Reset in cycle 20 aborts without a done pulse.
    run_mul(16'h1234, 16'h5678, 0, 20, done_cyc, pulses, busy_after);
    chk("p7_rst_pulses", 64'(pulses), 64'd0);
    chk("p7_rst_product", 64'(product), 64'd0);

    run_mul(16'h0012, 16'h0034, 0, 0, done_cyc, pulses, busy_after);
    chk("p8_product", 64'(product), 64'h00000408);
    chk("p8_overflow", 64'(overflow), 64'd0);
`ifdef BCD_MUL_EARLY_EXIT_EN
    chk("p8_latency", 64'(done_cyc), 64'd12);
`else
    chk("p8_latency", 64'(done_cyc), 64'd41);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
